// File: rtl/perf_counter_multi.sv
// Avalon-MM profiling counters: per-section cycle/entry counters, all gated by section 0's run bit.
// Read latency 1 cycle (readdata registered from address every clock); no waitrequest, so the slave never backpressures.
module perf_counter_multi #(
  parameter int NUM_SECTIONS = 8,
  parameter int TIME_WIDTH   = 64,
  parameter int EVENT_WIDTH  = 32,
  parameter bit SATURATE     = 1'b0,
  parameter int ADDR_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  begintransfer,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata
);
  localparam int SNAP_WIDTH = TIME_WIDTH - 32;

  logic [TIME_WIDTH-1:0]   time_cnt  [NUM_SECTIONS];
  logic [EVENT_WIDTH-1:0]  event_cnt [NUM_SECTIONS];
  logic [SNAP_WIDTH-1:0]   snap      [NUM_SECTIONS];
  logic [NUM_SECTIONS-1:0] run;
  logic [NUM_SECTIONS-1:0] ovf;

  logic [ADDR_WIDTH+1:0]   addr_ext;
  logic [ADDR_WIDTH-1:0]   sec;
  logic [1:0]              reg_sel;
  logic                    wr_s;
  logic                    rd_s;
  logic                    gr;
  logic                    gen;
  logic [NUM_SECTIONS-1:0] sel;
  logic [NUM_SECTIONS-1:0] go;
  logic [NUM_SECTIONS-1:0] stop;
  logic [NUM_SECTIONS-1:0] ovf_clr;
  logic [NUM_SECTIONS-1:0] time_inc;
  logic [NUM_SECTIONS-1:0] event_inc;
  logic [NUM_SECTIONS-1:0] ovf_set;
  logic [31:0]             rd_mux;
  logic                    unused_writedata;

  // Zero-padding keeps the section/register split legal for the smallest address widths.
  assign addr_ext         = {2'b00, address};
  assign sec              = addr_ext[ADDR_WIDTH+1:2];
  assign reg_sel          = addr_ext[1:0];
  assign wr_s             = write && begintransfer;
  assign rd_s             = read && begintransfer;
  assign unused_writedata = ^writedata[31:2];

  // Sections at or above NUM_SECTIONS match no sel bit, so they read 0 and ignore writes.
  always_comb begin
    for (int s = 0; s < NUM_SECTIONS; s++) begin
      sel[s]     = (int'(sec) == s);
      go[s]      = wr_s && sel[s] && (reg_sel == 2'd1);
      stop[s]    = wr_s && sel[s] && (reg_sel == 2'd0);
      ovf_clr[s] = wr_s && sel[s] && (reg_sel == 2'd3) && writedata[1];
    end
  end

  assign gr  = stop[0] && writedata[0];
  assign gen = run[0] || go[0];

  always_comb begin
    for (int s = 0; s < NUM_SECTIONS; s++) begin
      time_inc[s]  = run[s] && gen;
      event_inc[s] = go[s] && gen;
      ovf_set[s]   = (time_inc[s] && (&time_cnt[s])) || (event_inc[s] && (&event_cnt[s]));
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_SECTIONS; s++) begin
      if (reset || gr) begin
        time_cnt[s]  <= '0;
        event_cnt[s] <= '0;
        snap[s]      <= '0;
        run[s]       <= 1'b0;
        ovf[s]       <= 1'b0;
      end else begin
        if (time_inc[s] && !(SATURATE && (&time_cnt[s])))
          time_cnt[s] <= time_cnt[s] + TIME_WIDTH'(1);
        if (event_inc[s] && !(SATURATE && (&event_cnt[s])))
          event_cnt[s] <= event_cnt[s] + EVENT_WIDTH'(1);
        // A new overflow outranks a software clear landing in the same cycle.
        if (ovf_set[s])
          ovf[s] <= 1'b1;
        else if (ovf_clr[s])
          ovf[s] <= 1'b0;
        if (go[s])
          run[s] <= 1'b1;
        else if (stop[s])
          run[s] <= 1'b0;
        if (rd_s && sel[s] && (reg_sel == 2'd0))
          snap[s] <= time_cnt[s][TIME_WIDTH-1:32];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int s = 0; s < NUM_SECTIONS; s++) begin
      if (sel[s]) begin
        case (reg_sel)
          2'd0:    rd_mux = time_cnt[s][31:0];
          2'd1:    rd_mux = 32'(snap[s]);
          2'd2:    rd_mux = 32'(event_cnt[s]);
          default: rd_mux = {30'b0, ovf[s], run[s]};
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      readdata <= '0;
    else
      readdata <= rd_mux;
  end

endmodule

// File: tb/tb_perf_counter_multi.sv
// Bench for perf_counter_multi: wrap and saturate instances share stimulus and are checked against a behavioural model.
module tb_perf_counter_multi;
  localparam int NS = 6;
  localparam int TW = 40;
  localparam int EW = 4;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic          begintransfer;
  logic          read;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   rd0;
  logic [31:0]   rd1;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  longint unsigned m_time [2][NS];
  longint unsigned m_snap [2][NS];
  int              m_ev   [2][NS];
  bit              m_run  [2][NS];
  bit              m_ovf  [2][NS];
  logic [31:0]     m_rd   [2];

  always #5 clk = ~clk;

  perf_counter_multi #(.NUM_SECTIONS(NS), .TIME_WIDTH(TW), .EVENT_WIDTH(EW), .SATURATE(1'b0), .ADDR_WIDTH(AW))
    u_dut_wrap (.clk(clk), .reset(reset), .address(address), .begintransfer(begintransfer),
                .read(read), .write(write), .writedata(writedata), .readdata(rd0));

  perf_counter_multi #(.NUM_SECTIONS(NS), .TIME_WIDTH(TW), .EVENT_WIDTH(EW), .SATURATE(1'b1), .ADDR_WIDTH(AW))
    u_dut_sat (.clk(clk), .reset(reset), .address(address), .begintransfer(begintransfer),
               .read(read), .write(write), .writedata(writedata), .readdata(rd1));

  task automatic clear_model(int k);
    for (int s = 0; s < NS; s++) begin
      m_time[k][s] = 0;
      m_snap[k][s] = 0;
      m_ev[k][s]   = 0;
      m_run[k][s]  = 1'b0;
      m_ovf[k][s]  = 1'b0;
    end
  endtask

  // One clock of the register-level behaviour, evaluated on the inputs present at the edge.
  task automatic model_step();
    longint unsigned tmax;
    int  emax, sec, r;
    bit  wr, rd, vld, go, stop, gr, gen, oset;
    tmax = (64'd1 << TW) - 64'd1;
    emax = (1 << EW) - 1;
    sec  = int'(address) >> 2;
    r    = int'(address) & 3;
    vld  = sec < NS;
    wr   = write && begintransfer;
    rd   = read && begintransfer;
    go   = wr && vld && (r == 1);
    stop = wr && vld && (r == 0);
    gr   = stop && (sec == 0) && writedata[0];
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_rd[k] = '0;
        clear_model(k);
        continue;
      end
      m_rd[k] = '0;
      if (vld) begin
        case (r)
          0: m_rd[k] = 32'(m_time[k][sec]);
          1: m_rd[k] = 32'(m_snap[k][sec]);
          2: m_rd[k] = 32'(m_ev[k][sec]);
          default: m_rd[k] = {30'b0, m_ovf[k][sec], m_run[k][sec]};
        endcase
      end
      gen = m_run[k][0] || (go && sec == 0);
      if (gr) begin
        clear_model(k);
        continue;
      end
      for (int s = 0; s < NS; s++) begin
        oset = 1'b0;
        if (rd && vld && r == 0 && sec == s) m_snap[k][s] = m_time[k][s] >> 32;
        if (m_run[k][s] && gen) begin
          if (m_time[k][s] == tmax) begin
            oset = 1'b1;
            m_time[k][s] = (k == 1) ? tmax : 0;
          end else m_time[k][s] = m_time[k][s] + 1;
        end
        if (go && sec == s && gen) begin
          if (m_ev[k][s] == emax) begin
            oset = 1'b1;
            m_ev[k][s] = (k == 1) ? emax : 0;
          end else m_ev[k][s] = m_ev[k][s] + 1;
        end
        if (oset) m_ovf[k][s] = 1'b1;
        else if (wr && vld && r == 3 && sec == s && writedata[1]) m_ovf[k][s] = 1'b0;
        if (go && sec == s) m_run[k][s] = 1'b1;
        else if (stop && sec == s) m_run[k][s] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_idle();
    begintransfer = 1'b0;
    read          = 1'b0;
    write         = 1'b0;
  endtask

  task automatic idle(int n);
    set_idle();
    repeat (n) tick();
  endtask

  task automatic wr_reg(int s, int r, logic [31:0] d);
    address       = AW'(s * 4 + r);
    writedata     = d;
    write         = 1'b1;
    begintransfer = 1'b1;
    tick();
    set_idle();
  endtask

  task automatic rd_reg(int s, int r, output logic [31:0] v0, output logic [31:0] v1);
    address       = AW'(s * 4 + r);
    read          = 1'b1;
    begintransfer = 1'b1;
    tick();
    set_idle();
    v0 = rd0;
    v1 = rd1;
  endtask

  task automatic lit(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_reg(string name, int s, int r, logic [31:0] e_wrap, logic [31:0] e_sat);
    logic [31:0] v0, v1;
    rd_reg(s, r, v0, v1);
    lit({name, "/wrap"}, v0, e_wrap);
    lit({name, "/sat"}, v1, e_sat);
  endtask

  // Cycle-by-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        n_checks += 2;
        if (rd0 !== m_rd[0]) begin
          n_fail++;
          $display("FAIL model_rd_wrap t=%0t addr=%0d: got 0x%08h, expected 0x%08h", $time, address, rd0, m_rd[0]);
        end
        if (rd1 !== m_rd[1]) begin
          n_fail++;
          $display("FAIL model_rd_sat t=%0t addr=%0d: got 0x%08h, expected 0x%08h", $time, address, rd1, m_rd[1]);
        end
      end
    end
  end

  initial begin
    logic [31:0] v0, v1;
    reset     = 1'b1;
    address   = '0;
    writedata = '0;
    set_idle();
    for (int k = 0; k < 2; k++) clear_model(k);
    m_rd[0] = '0;
    m_rd[1] = '0;
    tick();
    chk_en = 1'b1;
    idle(2);
    reset = 1'b0;

    // Reset state: every address reads zero.
    for (int a = 0; a < 32; a++) chk_reg("reset_rd", a / 4, a % 4, 32'h0, 32'h0);

    // Basic measurement: section 1 nested inside section 0.
    wr_reg(0, 1, 0);
    wr_reg(1, 1, 0);
    idle(100);
    wr_reg(1, 0, 0);
    wr_reg(0, 0, 0);
    chk_reg("s1_event", 1, 2, 32'd1, 32'd1);
    chk_reg("s1_time", 1, 0, 32'd101, 32'd101);
    chk_reg("s0_time", 0, 0, 32'd103, 32'd103);
    chk_reg("s1_status", 1, 3, 32'd0, 32'd0);

    // Gating: section 2 running while section 0 is stopped.
    wr_reg(2, 1, 0);
    idle(50);
    chk_reg("gated_time", 2, 0, 32'd0, 32'd0);
    chk_reg("gated_event", 2, 2, 32'd0, 32'd0);
    chk_reg("gated_status", 2, 3, 32'd1, 32'd1);

    // Lo read returns pre-increment value; hi comes from the snapshot taken then.
    wr_reg(0, 1, 0);
    wr_reg(1, 1, 0);
    chk_reg("snap_lo", 1, 0, 32'd101, 32'd101);
    idle(40);
    chk_reg("snap_hi", 1, 1, 32'd0, 32'd0);

    // Event overflow: wrap versus saturate, then software clear.
    wr_reg(0, 0, 1);
    chk_reg("gr_s0_time", 0, 0, 32'd0, 32'd0);
    wr_reg(0, 1, 0);
    for (int i = 0; i < 17; i++) wr_reg(3, 1, 0);
    chk_reg("ovf_event", 3, 2, 32'd1, 32'd15);
    chk_reg("ovf_status", 3, 3, 32'd3, 32'd3);
    wr_reg(3, 3, 32'h2);
    chk_reg("ovf_cleared", 3, 3, 32'd1, 32'd1);

    // Global reset while everything runs.
    for (int s = 1; s < NS; s++) wr_reg(s, 1, 0);
    idle(20);
    wr_reg(0, 0, 32'h1);
    for (int a = 0; a < NS * 4; a++) chk_reg("gr_clear", a / 4, a % 4, 32'h0, 32'h0);

    // Hardware reset mid-run.
    wr_reg(0, 1, 0);
    wr_reg(2, 1, 0);
    address = AW'(0);
    idle(10);
    reset = 1'b1;
    tick();
    lit("reset_rdata/wrap", rd0, 32'h0);
    lit("reset_rdata/sat", rd1, 32'h0);
    reset = 1'b0;
    for (int a = 0; a < NS * 4; a++) chk_reg("reset_clear", a / 4, a % 4, 32'h0, 32'h0);

    // Unimplemented sections ignore writes and read zero.
    wr_reg(0, 1, 0);
    wr_reg(6, 1, 0);
    wr_reg(7, 3, 32'h2);
    idle(3);
    for (int a = NS * 4; a < 32; a++) chk_reg("oob_rd", a / 4, a % 4, 32'h0, 32'h0);

    // Multi-cycle write strobes only once; writes without begintransfer do nothing.
    address       = AW'(4 * 4 + 1);
    write         = 1'b1;
    begintransfer = 1'b1;
    tick();
    begintransfer = 1'b0;
    repeat (3) tick();
    write = 1'b0;
    tick();
    write = 1'b1;
    repeat (2) tick();
    set_idle();
    chk_reg("strobe_event", 4, 2, 32'd1, 32'd1);
    chk_reg("strobe_status", 4, 3, 32'd1, 32'd1);

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 4000; i++) begin
      reset         = ($urandom_range(0, 599) == 0);
      begintransfer = ($urandom_range(0, 2) != 0);
      write         = $urandom_range(0, 1) == 1;
      read          = !write && ($urandom_range(0, 1) == 1);
      address       = AW'($urandom_range(0, 31));
      writedata     = $urandom;
      if (address == 0 && $urandom_range(0, 29) != 0) writedata[0] = 1'b0;
      tick();
    end
    reset = 1'b0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
